// File: rtl/stream_demultiplexer.sv
// stream_demultiplexer
// Routes one valid/ready input stream to one of in_outputs channels chosen
// per beat by in_sel. Every channel has its own 2-entry FIFO so a stalled
// consumer only blocks beats aimed at it. Beats with an out-of-range select
// are accepted, discarded and counted in a saturating drop counter.
//
// Handshake rule (both sides): a beat transfers on a rising edge where
// valid && ready are both high. The producer holds in_data/in_sel stable
// while in_valid && !in_ready. out_valid[k]/out_data[k] hold stable while
// out_valid[k] && !out_ready[k]. in_ready is a function of rst, in_sel and
// the registered channel counts only. It never looks at out_ready, so there
// is no combinational ready path from any consumer back to the producer.
module stream_demultiplexer #(
  parameter int in_bitwidth = 1,
  parameter int in_outputs  = 16,
  parameter int log2ofout   = ($clog2(in_outputs) > 0) ? $clog2(in_outputs) : 1,
  parameter int cnt_width   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [in_bitwidth-1:0] in_data,
  input  logic [log2ofout-1:0]   in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [in_bitwidth-1:0] out_data [in_outputs-1:0],
  output logic [in_outputs-1:0]  out_valid,
  input  logic [in_outputs-1:0]  out_ready,
  output logic [cnt_width-1:0]   drop_cnt
);

  // Per-channel FIFO state: 2 storage slots, 1-bit pointers, 0..2 count.
  logic [in_bitwidth-1:0] mem_q    [in_outputs-1:0][2];
  logic [in_bitwidth-1:0] mem_d    [in_outputs-1:0][2];
  logic [1:0]             count_q  [in_outputs-1:0];
  logic [1:0]             count_d  [in_outputs-1:0];
  logic [in_outputs-1:0]  wr_ptr_q, wr_ptr_d;
  logic [in_outputs-1:0]  rd_ptr_q, rd_ptr_d;
  logic [cnt_width-1:0]   drop_cnt_q, drop_cnt_d;

  // Decode and handshake terms.
  logic [in_outputs-1:0]  sel_hit;
  logic [in_outputs-1:0]  full;
  logic [in_outputs-1:0]  push;
  logic [in_outputs-1:0]  pop;
  logic                   sel_in_range;
  logic                   target_full;
  logic                   accept;
  logic                   drop;

  // One-hot decode of in_sel; an out-of-range select decodes to all zeros.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < in_outputs; k++) begin
      sel_hit[k] = (in_sel == log2ofout'(k));
    end
  end

  // Full flags come straight from the registered counts.
  always_comb begin
    full = '0;
    for (int k = 0; k < in_outputs; k++) begin
      full[k] = (count_q[k] == 2'd2);
    end
  end

  // Input handshake: stall only when the addressed channel is full.
  always_comb begin
    sel_in_range = |sel_hit;
    target_full  = |(sel_hit & full);
    in_ready     = !rst && !target_full;
    accept       = in_valid && in_ready;
    drop         = accept && !sel_in_range;
    push         = accept ? sel_hit : '0;
    pop          = out_valid & out_ready;
  end

  // FIFO next state: write at wr_ptr on push, advance rd_ptr on pop.
  always_comb begin
    mem_d    = mem_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int k = 0; k < in_outputs; k++) begin
      if (push[k]) begin
        mem_d[k][wr_ptr_q[k]] = in_data;
        wr_ptr_d[k]           = ~wr_ptr_q[k];
      end
      if (pop[k]) begin
        rd_ptr_d[k] = ~rd_ptr_q[k];
      end
      case ({push[k], pop[k]})
        2'b10:   count_d[k] = count_q[k] + 2'd1;
        2'b01:   count_d[k] = count_q[k] - 2'd1;
        default: count_d[k] = count_q[k];
      endcase
    end
  end

  // Drop counter: count accepted out-of-range beats, hold at all-ones.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != {cnt_width{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // Control state register; reset empties every channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < in_outputs; k++) begin
        count_q[k] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Payload storage; contents are only visible through a non-zero count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Output view: head entry when non-empty, zero otherwise.
  always_comb begin
    for (int k = 0; k < in_outputs; k++) begin
      out_valid[k] = (count_q[k] != 2'd0);
      out_data[k]  = out_valid[k] ? mem_q[k][rd_ptr_q[k]] : '0;
    end
    drop_cnt = drop_cnt_q;
  end

endmodule
